// File: rtl/glb_sequencer_pkg.sv
// Shared types for the global-buffer sequencer: buffer opcodes and FSM states.
package glb_sequencer_pkg;

  typedef enum logic [3:0] {
    I_NOP             = 4'd0,
    I_POINTER_RESET   = 4'd1,
    I_LOAD_WEIGHT     = 4'd2,
    I_LOAD_ACTIVATION = 4'd3,
    I_LOAD_OUTPUT     = 4'd4,
    I_READ_ACTIVATION = 4'd5
  } global_buffer_instruction_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DONE
  } glb_seq_state_t;

endpackage

// File: rtl/glb_beat_counter.sv
// Down-counter of outstanding beats; o_last flags the final beat of a transfer.
module glb_beat_counter #(
  parameter int countWidth = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [countWidth-1:0] i_load_val,
  input  logic                  i_dec,
  output logic [countWidth-1:0] o_remaining,
  output logic                  o_last
);

  logic [countWidth-1:0] r_remaining;

  // Decrement saturates at zero so a stray beat can never wrap the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remaining <= '0;
    end else if (i_load) begin
      r_remaining <= i_load_val;
    end else if (i_dec && (r_remaining != '0)) begin
      r_remaining <= r_remaining - countWidth'(1);
    end
  end

  assign o_remaining = r_remaining;
  assign o_last      = (r_remaining == countWidth'(1));

endmodule

// File: rtl/glb_sequencer.sv
// Instruction-driven global-buffer sequencer: latches start addresses and
// streams a counted number of beats between source/sink and the buffer port.
module glb_sequencer
  import glb_sequencer_pkg::*;
#(
  parameter int dataSize       = 8,
  parameter int interfaceDepth = 16,
  parameter int addrWidth      = 32,
  parameter int countWidth     = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [3:0]                         instr_i,
  input  logic [addrWidth-1:0]               instr_addr_i,
  input  logic [countWidth-1:0]              instr_len_i,
  input  logic                               instr_valid_i,
  output logic                               instr_ready_o,
  input  logic [interfaceDepth*dataSize-1:0] src_data_i,
  input  logic                               src_valid_i,
  output logic                               src_ready_o,
  output logic [interfaceDepth*dataSize-1:0] dst_data_o,
  output logic                               dst_valid_o,
  output logic [3:0]                         buf_instr_o,
  output logic [addrWidth-1:0]               weight_start_addr_o,
  output logic [addrWidth-1:0]               activation_start_addr_o,
  output logic [interfaceDepth*dataSize-1:0] buf_wr_data_o,
  output logic                               buf_wr_en_o,
  input  logic                               buf_ready_i,
  input  logic [interfaceDepth*dataSize-1:0] buf_rd_data_i,
  input  logic                               buf_rd_data_valid_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o
);

  glb_seq_state_t        r_state;
  logic [3:0]            r_buf_instr;
  logic [addrWidth-1:0]  r_weight_addr;
  logic [addrWidth-1:0]  r_act_addr;
  logic                  r_done;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_in_write;
  logic                  w_in_read;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_len_nz;
  logic [countWidth-1:0] w_remaining;

  assign w_accept   = instr_valid_i & (r_state == S_IDLE);
  assign w_in_write = (r_state == S_WRITE);
  assign w_in_read  = (r_state == S_READ);
  assign w_beat     = (w_in_write & src_valid_i & buf_ready_i) |
                      (w_in_read & buf_rd_data_valid_i);
  assign w_len_nz   = (instr_len_i != '0);

  glb_beat_counter #(
    .countWidth (countWidth)
  ) u_beat_counter (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_load_val  (instr_len_i),
    .i_dec       (w_beat),
    .o_remaining (w_remaining),
    .o_last      (w_last)
  );

  // Zero-length transfers fall straight through to DONE after the address update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_buf_instr   <= I_NOP;
      r_weight_addr <= '0;
      r_act_addr    <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (instr_valid_i) begin
            r_buf_instr <= instr_i;
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            case (instr_i)
              I_NOP: ;
              I_POINTER_RESET: begin
                r_weight_addr <= '0;
                r_act_addr    <= '0;
              end
              I_LOAD_WEIGHT, I_LOAD_ACTIVATION, I_LOAD_OUTPUT: begin
                if (instr_i == I_LOAD_WEIGHT)     r_weight_addr <= instr_addr_i;
                if (instr_i == I_LOAD_ACTIVATION) r_act_addr    <= instr_addr_i;
                if (w_len_nz) begin
                  r_state <= S_WRITE;
                  r_done  <= 1'b0;
                end
              end
              I_READ_ACTIVATION: begin
                r_act_addr <= instr_addr_i;
                if (w_len_nz) begin
                  r_state <= S_READ;
                  r_done  <= 1'b0;
                end
              end
              default: r_err <= 1'b1;
            endcase
          end
        end
        S_WRITE, S_READ: begin
          if (w_beat && w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_buf_instr <= I_NOP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready_o           = (r_state == S_IDLE);
  assign busy_o                  = (r_state != S_IDLE);
  assign done_o                  = r_done;
  assign err_o                   = r_err;
  assign buf_instr_o             = r_buf_instr;
  assign weight_start_addr_o     = r_weight_addr;
  assign activation_start_addr_o = r_act_addr;

  assign buf_wr_data_o = src_data_i;
  assign buf_wr_en_o   = w_in_write & src_valid_i;
  assign src_ready_o   = w_in_write & buf_ready_i;

  assign dst_data_o  = buf_rd_data_i;
  assign dst_valid_o = w_in_read & buf_rd_data_valid_i;

endmodule

// File: tb/tb_glb_sequencer.sv
// Self-checking bench for glb_sequencer: directed instruction table, hand
// sequences for held-valid and mid-transfer reset, then randomized traffic.
module tb_glb_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   instr_i;
  logic [31:0]  instr_addr_i;
  logic [15:0]  instr_len_i;
  logic         instr_valid_i;
  logic         instr_ready_o;
  logic [127:0] src_data_i;
  logic         src_valid_i;
  logic         src_ready_o;
  logic [127:0] dst_data_o;
  logic         dst_valid_o;
  logic [3:0]   buf_instr_o;
  logic [31:0]  weight_start_addr_o;
  logic [31:0]  activation_start_addr_o;
  logic [127:0] buf_wr_data_o;
  logic         buf_wr_en_o;
  logic         buf_ready_i;
  logic [127:0] buf_rd_data_i;
  logic         buf_rd_data_valid_i;
  logic         busy_o;
  logic         done_o;
  logic         err_o;

  int n_checks = 0;
  int n_err    = 0;

  glb_sequencer dut (
    .clk                     (clk),
    .rst                     (rst),
    .instr_i                 (instr_i),
    .instr_addr_i            (instr_addr_i),
    .instr_len_i             (instr_len_i),
    .instr_valid_i           (instr_valid_i),
    .instr_ready_o           (instr_ready_o),
    .src_data_i              (src_data_i),
    .src_valid_i             (src_valid_i),
    .src_ready_o             (src_ready_o),
    .dst_data_o              (dst_data_o),
    .dst_valid_o             (dst_valid_o),
    .buf_instr_o             (buf_instr_o),
    .weight_start_addr_o     (weight_start_addr_o),
    .activation_start_addr_o (activation_start_addr_o),
    .buf_wr_data_o           (buf_wr_data_o),
    .buf_wr_en_o             (buf_wr_en_o),
    .buf_ready_i             (buf_ready_i),
    .buf_rd_data_i           (buf_rd_data_i),
    .buf_rd_data_valid_i     (buf_rd_data_valid_i),
    .busy_o                  (busy_o),
    .done_o                  (done_o),
    .err_o                   (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issues one instruction and follows it to completion. The expected behaviour
  // is derived from counting the handshakes this bench itself offers: while
  // fewer than the requested beats have been offered the transfer is active,
  // and the cycle after the last beat must be the done cycle.
  task automatic run_instr(input logic [3:0] op, input logic [31:0] addr,
                           input logic [15:0] len, input logic [15:0] mask,
                           input bit rnd, output int done_cyc);
    bit   isw, isr;
    int   nb, cnt;
    logic sv, br, rv, m;
    isw = (op == 4'd2) || (op == 4'd3) || (op == 4'd4);
    isr = (op == 4'd5);
    nb  = (isw || isr) ? int'(len) : 0;
    @(negedge clk);
    instr_i = op; instr_addr_i = addr; instr_len_i = len; instr_valid_i = 1'b1;
    src_valid_i = 1'b0; buf_ready_i = 1'b0; buf_rd_data_valid_i = 1'b0;
    #1 chk("ready_before_accept", instr_ready_o, 1'b1);
    cnt = 0;
    done_cyc = -1;
    for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
      @(negedge clk);
      instr_valid_i = 1'b0;
      instr_i = 4'($urandom);
      m = (c <= 16) ? mask[c-1] : 1'b1;
      if (rnd) begin
        sv = 1'($urandom); br = 1'($urandom); rv = 1'($urandom);
      end else begin
        sv = 1'b1; br = isw ? m : 1'b1; rv = isr ? m : 1'b1;
      end
      src_valid_i = sv; buf_ready_i = br; buf_rd_data_valid_i = rv;
      src_data_i = rnd128(); buf_rd_data_i = rnd128();
      #1;
      if (c == 1) begin
        chk("buf_instr_at_T1", buf_instr_o, op);
        if (op == 4'd2) chk("weight_addr_at_T1", weight_start_addr_o, addr);
        if (op == 4'd3 || op == 4'd5) chk("act_addr_at_T1", activation_start_addr_o, addr);
      end
      if (cnt < nb) begin
        chk("xfer_wr_en", buf_wr_en_o, isw & sv);
        chk("xfer_src_ready", src_ready_o, isw & br);
        chk("xfer_dst_valid", dst_valid_o, isr & rv);
        chk("xfer_done_low", done_o, 1'b0);
        chk("xfer_busy", busy_o, 1'b1);
        if (isw && sv) chk("wr_data", buf_wr_data_o, src_data_i);
        if (isr && rv) chk("rd_data", dst_data_o, buf_rd_data_i);
        if ((isw && sv && br) || (isr && rv)) cnt++;
      end else begin
        chk("done_pulse", done_o, 1'b1);
        chk("done_no_wr_en", buf_wr_en_o, 1'b0);
        chk("done_no_dst_valid", dst_valid_o, 1'b0);
        chk("done_buf_instr", buf_instr_o, op);
        done_cyc = c;
      end
    end
    if (done_cyc < 0) begin
      n_checks++;
      n_err++;
      $display("FAIL done_timeout: got no done_o within 300 cycles, required one");
    end
    @(negedge clk);
    src_valid_i = 1'b0; buf_ready_i = 1'b0; buf_rd_data_valid_i = 1'b0;
    #1;
    chk("idle_done_low", done_o, 1'b0);
    chk("idle_ready", instr_ready_o, 1'b1);
    chk("idle_busy", busy_o, 1'b0);
    chk("idle_buf_instr_nop", buf_instr_o, 4'd0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [15:0] len;
    logic [15:0] mask;
    int          exp_done;
    logic [31:0] exp_wa;
    logic [31:0] exp_aa;
    logic        exp_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int   dc;
    logic [31:0] mwa, maa;
    logic        merr;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [15:0] len;
    int          r;

    tbl[0] = '{4'd2, 32'h100, 16'd4, 16'hFFFF, 5, 32'h100, 32'h0,   1'b0};
    tbl[1] = '{4'd3, 32'h200, 16'd3, 16'h0015, 6, 32'h100, 32'h200, 1'b0};
    tbl[2] = '{4'd5, 32'h40,  16'd2, 16'h0012, 6, 32'h100, 32'h40,  1'b0};
    tbl[3] = '{4'd2, 32'h300, 16'd0, 16'hFFFF, 1, 32'h300, 32'h40,  1'b0};
    tbl[4] = '{4'd1, 32'h777, 16'd5, 16'hFFFF, 1, 32'h0,   32'h0,   1'b0};
    tbl[5] = '{4'd9, 32'h55,  16'd3, 16'hFFFF, 1, 32'h0,   32'h0,   1'b1};
    tbl[6] = '{4'd4, 32'h999, 16'd2, 16'hFFFF, 3, 32'h0,   32'h0,   1'b1};
    tbl[7] = '{4'd2, 32'h10,  16'd1, 16'hFFFF, 2, 32'h10,  32'h0,   1'b1};

    rst = 1'b1;
    instr_i = 4'd0; instr_addr_i = '0; instr_len_i = '0; instr_valid_i = 1'b0;
    src_data_i = '0; src_valid_i = 1'b1; buf_ready_i = 1'b1;
    buf_rd_data_i = '0; buf_rd_data_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", instr_ready_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_buf_instr", buf_instr_o, 4'd0);
    chk("rst_weight_addr", weight_start_addr_o, 32'h0);
    chk("rst_act_addr", activation_start_addr_o, 32'h0);
    chk("rst_wr_en", buf_wr_en_o, 1'b0);
    chk("rst_src_ready", src_ready_o, 1'b0);
    chk("rst_dst_valid", dst_valid_o, 1'b0);

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].addr, tbl[i].len, tbl[i].mask, 1'b0, dc);
      chk($sformatf("tbl%0d_done_cycle", i), 128'(dc), 128'(tbl[i].exp_done));
      chk($sformatf("tbl%0d_weight_addr", i), weight_start_addr_o, tbl[i].exp_wa);
      chk($sformatf("tbl%0d_act_addr", i), activation_start_addr_o, tbl[i].exp_aa);
      chk($sformatf("tbl%0d_err", i), err_o, tbl[i].exp_err);
    end

    // instr_valid held high across DONE: re-accepted at the first IDLE edge.
    @(negedge clk);
    instr_i = 4'd0; instr_len_i = '0; instr_valid_i = 1'b1;
    @(negedge clk); #1 chk("held_c1_done", done_o, 1'b1);
    @(negedge clk); #1 chk("held_c2_done", done_o, 1'b0);
    chk("held_c2_ready", instr_ready_o, 1'b1);
    @(negedge clk); instr_valid_i = 1'b0;
    #1 chk("held_c3_done", done_o, 1'b1);
    @(negedge clk); #1 chk("held_c4_done", done_o, 1'b0);

    // Reset after 2 of 5 beats: everything returns to reset values at once.
    @(negedge clk);
    instr_i = 4'd2; instr_addr_i = 32'h500; instr_len_i = 16'd5; instr_valid_i = 1'b1;
    src_valid_i = 1'b1; buf_ready_i = 1'b1;
    @(negedge clk); instr_valid_i = 1'b0;
    #1 chk("abort_beat1", buf_wr_en_o, 1'b1);
    chk("abort_addr", weight_start_addr_o, 32'h500);
    @(negedge clk); #1 chk("abort_beat2", buf_wr_en_o, 1'b1);
    @(negedge clk); #1 chk("abort_busy_before", busy_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_ready", instr_ready_o, 1'b1);
    chk("abort_done", done_o, 1'b0);
    chk("abort_wr_en", buf_wr_en_o, 1'b0);
    chk("abort_weight_addr", weight_start_addr_o, 32'h0);
    chk("abort_err_cleared", err_o, 1'b0);
    chk("abort_buf_instr", buf_instr_o, 4'd0);
    @(negedge clk); rst = 1'b0; src_valid_i = 1'b0; buf_ready_i = 1'b0;
    #1 chk("abort_no_done", done_o, 1'b0);
    run_instr(4'd3, 32'h20, 16'd2, 16'hFFFF, 1'b0, dc);
    chk("post_abort_done_cycle", 128'(dc), 128'd3);
    chk("post_abort_act_addr", activation_start_addr_o, 32'h20);

    // Randomized traffic against an instruction-level address/error model.
    mwa = 32'h0; maa = 32'h20; merr = 1'b0;
    for (int k = 0; k < 40; k++) begin
      r    = $urandom_range(0, 15);
      op   = (r < 13) ? 4'(r % 6) : 4'($urandom_range(6, 15));
      addr = $urandom;
      len  = 16'($urandom_range(0, 6));
      case (op)
        4'd0, 4'd4: ;
        4'd1: begin mwa = 32'h0; maa = 32'h0; end
        4'd2: mwa = addr;
        4'd3, 4'd5: maa = addr;
        default: merr = 1'b1;
      endcase
      run_instr(op, addr, len, 16'h0, 1'b1, dc);
      chk("rnd_weight_addr", weight_start_addr_o, mwa);
      chk("rnd_act_addr", activation_start_addr_o, maa);
      chk("rnd_err", err_o, merr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
